crc_generator_16bit_tx: RTL and testbench

- Transmit-side CRC16 generator for the USB data-packet path. It is the TX counterpart of the 16-bit CRC checker.
- Accepts payload bytes over a valid/ready handshake and serializes each byte LSb-first, one bit per `shift_strobe` from the TX bit timer.
- Updates the CRC16 (x^16+x^15+x^2+1) on every payload bit, then appends the complemented 16-bit remainder MSb-first.
- Sits between the TX packet FSM (byte source) and the bit stuffer / NRZI encoder (bit sink).

---
 rtl/usb_tx_pkg.sv | 13 +
 rtl/crc16_lfsr_step.sv | 16 +
 rtl/crc_generator_16bit_tx.sv | 154 +++++++++++++++
 tb/tb_crc_generator_16bit_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared constants and state encoding for the USB TX CRC16 path.
// No logic; imported by the generator and its LFSR step.
package usb_tx_pkg;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } crc_tx_state_t;
endpackage

// File: rtl/crc16_lfsr_step.sv
// One-bit CRC16 update: shift left, fold in POLY when din differs from the MSb.
// Latency: combinational. Backpressure: none.
module crc16_lfsr_step
  import usb_tx_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY
) (
  input  logic [15:0] crc_in,
  input  logic        din,
  output logic [15:0] crc_out
);
  logic fb;

  assign fb      = din ^ crc_in[15];
  assign crc_out = {crc_in[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
endmodule

// File: rtl/crc_generator_16bit_tx.sv
// USB TX CRC16 generator: serializes payload LSb-first, then appends ~CRC MSb-first (CRC_TX_UNDERRUN_EN adds underrun abort).
// Latency: accepted byte drives bit_out the next cycle; one bit per shift_strobe; done one cycle after the last CRC bit.
// Backpressure: tx_ready is a registered "shifter empty in DATA"; a byte is held off until all 8 bits are strobed out.
module crc_generator_16bit_tx
  import usb_tx_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY,
  parameter logic [15:0] INIT = CRC16_INIT
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       start,
  input  logic       zero_len,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       shift_strobe,
  output logic       bit_out,
  output logic       bit_active,
  output logic       busy,
`ifdef CRC_TX_UNDERRUN_EN
  output logic       done,
  output logic       underrun
`else
  output logic       done
`endif
);
  crc_tx_state_t state_q, state_d;
  logic [15:0]   crc_q, crc_d;
  logic [7:0]    sh_q, sh_d;
  logic          full_q, full_d;
  logic          last_q, last_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic [15:0]   crc_next;
`ifdef CRC_TX_UNDERRUN_EN
  logic          underrun_q, underrun_d;
`endif

  crc16_lfsr_step #(.POLY(POLY)) u_step (
    .crc_in  (crc_q),
    .din     (sh_q[0]),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    sh_d    = sh_q;
    full_d  = full_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
`ifdef CRC_TX_UNDERRUN_EN
    underrun_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          crc_d   = INIT;
          cnt_d   = 4'd0;
          full_d  = 1'b0;
          last_d  = 1'b0;
          state_d = zero_len ? CRC : DATA;
        end
      end
      DATA: begin
        if (full_q) begin
          if (shift_strobe) begin
            crc_d = crc_next;
            sh_d  = {1'b0, sh_q[7:1]};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              full_d = 1'b0;
              if (last_q) begin
                state_d = CRC;
                cnt_d   = 4'd0;
              end
            end
          end
        end else begin
`ifdef CRC_TX_UNDERRUN_EN
          if (shift_strobe) begin
            underrun_d = 1'b1;
            state_d    = IDLE;
          end else if (tx_valid && ready_q) begin
`else
          // An empty-shifter strobe is simply dropped here.
          if (tx_valid && ready_q) begin
`endif
            sh_d   = tx_data;
            last_d = tx_last;
            cnt_d  = 4'd0;
            full_d = 1'b1;
          end
        end
      end
      CRC: begin
        if (shift_strobe) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == DATA) && !full_d;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      sh_q    <= 8'h00;
      full_q  <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      sh_q    <= sh_d;
      full_q  <= full_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

`ifdef CRC_TX_UNDERRUN_EN
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) underrun_q <= 1'b0;
    else       underrun_q <= underrun_d;
  end
  assign underrun = underrun_q;
`endif

  // In CRC state ~cnt_q is 15-cnt_q, walking the remainder MSb-first.
  always_comb begin
    bit_active = 1'b0;
    bit_out    = 1'b0;
    if (state_q == DATA && full_q) begin
      bit_active = 1'b1;
      bit_out    = sh_q[0];
    end else if (state_q == CRC) begin
      bit_active = 1'b1;
      bit_out    = ~crc_q[~cnt_q];
    end
  end

  assign tx_ready = ready_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
endmodule

// File: tb/tb_crc_generator_16bit_tx.sv
// Directed bench for crc_generator_16bit_tx with an expected-bit scoreboard queue.
module tb_crc_generator_16bit_tx;
  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       start = 1'b0;
  logic       zero_len = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       shift_strobe = 1'b0;
  logic       tx_ready, bit_out, bit_active, busy, done;
`ifdef CRC_TX_UNDERRUN_EN
  logic       underrun;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_q[$];
  bit rx_q[$];
  logic [15:0] ref_crc;
  logic [15:0] crc_b2b;

  crc_generator_16bit_tx dut (
    .clk          (clk),
    .nRst         (nRst),
    .start        (start),
    .zero_len     (zero_len),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .shift_strobe (shift_strobe),
    .bit_out      (bit_out),
    .bit_active   (bit_active),
    .busy         (busy),
`ifdef CRC_TX_UNDERRUN_EN
    .done         (done),
    .underrun     (underrun)
`else
    .done         (done)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_step(input logic [15:0] c, input logic b);
    logic [15:0] r;
    r = c << 1;
    if (b != c[15]) r = r ^ 16'h8005;
    return r;
  endfunction

  // Receiver-side check: recompute CRC over payload, compare to trailing 16 bits.
  function automatic bit rx_crc_err(input bit s[$]);
    logic [15:0] c;
    bit          e;
    int          n;
    n = s.size();
    c = 16'hFFFF;
    e = 1'b0;
    if (n < 16) return 1'b1;
    for (int i = 0; i < n - 16; i++) c = model_step(c, s[i]);
    for (int j = 0; j < 16; j++) if (s[n-16+j] != ~c[15-j]) e = 1'b1;
    return e;
  endfunction

  function automatic logic [15:0] rx_tail(input bit s[$]);
    logic [15:0] w;
    int          n;
    n = s.size();
    w = 16'h0000;
    if (n >= 16) for (int j = 0; j < 16; j++) w[15-j] = s[n-16+j];
    return w;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic zl);
    start = 1'b1;
    zero_len = zl;
    ref_crc = 16'hFFFF;
    rx_q.delete();
    cyc(1);
    start = 1'b0;
    zero_len = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int k;
    k = 0;
    while (!tx_ready && k < 40) begin
      cyc(1);
      k++;
    end
    chk1("tx_ready_wait", tx_ready, 1'b1);
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = last;
    cyc(1);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[i]);
      ref_crc = model_step(ref_crc, d[i]);
    end
  endtask

  task automatic push_crc();
    for (int i = 15; i >= 0; i--) exp_q.push_back(~ref_crc[i]);
  endtask

  task automatic strobe(input string tag, input int gap);
    bit e;
    if (gap > 0) cyc(gap);
    chk1({tag, "_qnonempty"}, exp_q.size() != 0, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b0;
    chk1({tag, "_active"}, bit_active, 1'b1);
    chk1({tag, "_bit"}, bit_out, e);
    rx_q.push_back(bit_out);
    shift_strobe = 1'b1;
    cyc(1);
    shift_strobe = 1'b0;
  endtask

  task automatic strobes(input string tag, input int n, input int max_gap);
    for (int i = 0; i < n; i++) strobe(tag, $urandom_range(max_gap, 0));
  endtask

  task automatic finish_pkt(input string tag);
    chk1({tag, "_done"}, done, 1'b1);
    chk1({tag, "_busy_in_done"}, busy, 1'b1);
    chk1({tag, "_qdrained"}, exp_q.size() == 0, 1'b1);
    cyc(1);
    chk1({tag, "_done_clr"}, done, 1'b0);
    chk1({tag, "_busy_clr"}, busy, 1'b0);
    chk1({tag, "_inactive"}, bit_active, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk1({tag, "_tx_ready"}, tx_ready, 1'b0);
    chk1({tag, "_bit_out"}, bit_out, 1'b0);
    chk1({tag, "_bit_active"}, bit_active, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
`ifdef CRC_TX_UNDERRUN_EN
    chk1({tag, "_underrun"}, underrun, 1'b0);
`endif
  endtask

  initial begin
    cyc(2);
    check_idle_outputs("reset");
    nRst = 1'b1;
    cyc(1);

    // Empty packet: CRC of nothing is ~INIT = sixteen zeros.
    pulse_start(1'b1);
    chk1("empty_busy", busy, 1'b1);
    chk1("empty_ready", tx_ready, 1'b0);
    push_crc();
    strobes("empty", 16, 0);
    chk16("empty_crc_bits", rx_tail(rx_q), 16'h0000);
    finish_pkt("empty");

    // Single 0x00 byte.
    pulse_start(1'b0);
    chk1("b0_ready", tx_ready, 1'b1);
    send_byte(8'h00, 1'b1);
    chk1("b0_ready_busy", tx_ready, 1'b0);
    push_crc();
    strobes("b0", 24, 2);
    chk16("b0_crc_bits", rx_tail(rx_q), 16'h02FD);
    finish_pkt("b0");

    // Multi-byte stream with random strobe spacing, checked by a receiver model.
    pulse_start(1'b0);
    for (int b = 0; b < 4; b++) begin
      send_byte(8'(b), b == 3);
      strobes("multi", 8, 9);
    end
    push_crc();
    strobes("multi_crc", 16, 9);
    chk1("loop_crc_ok", rx_crc_err(rx_q), 1'b0);
    crc_b2b = rx_tail(rx_q);
    rx_q[5] = ~rx_q[5];
    chk1("loop_flip_detect", rx_crc_err(rx_q), 1'b1);
    finish_pkt("multi");

    // Backpressure gaps between bytes.
    pulse_start(1'b0);
    for (int b = 0; b < 4; b++) begin
      send_byte(8'(b), b == 3);
      strobes("bp", 8, 1);
      if (b < 3) begin
        for (int g = 0; g < 5; g++) begin
          cyc(1);
          chk1("bp_ready", tx_ready, 1'b1);
          chk1("bp_idle_bit", bit_active, 1'b0);
        end
      end
    end
    push_crc();
    strobes("bp_crc", 16, 1);
    chk16("bp_same_crc", rx_tail(rx_q), crc_b2b);
    finish_pkt("bp");

    // Strobe while the shifter is empty.
    pulse_start(1'b0);
    send_byte(8'h00, 1'b0);
    strobes("ur", 8, 0);
    chk1("ur_empty_inactive", bit_active, 1'b0);
    shift_strobe = 1'b1;
    cyc(1);
    shift_strobe = 1'b0;
`ifdef CRC_TX_UNDERRUN_EN
    chk1("ur_pulse", underrun, 1'b1);
    chk1("ur_idle", busy, 1'b0);
    chk1("ur_no_done", done, 1'b0);
    cyc(1);
    chk1("ur_pulse_clr", underrun, 1'b0);
    chk1("ur_no_done2", done, 1'b0);
    exp_q.delete();
`else
    chk1("ur_still_busy", busy, 1'b1);
    chk1("ur_still_ready", tx_ready, 1'b1);
    for (int b = 1; b < 4; b++) begin
      send_byte(8'(b), b == 3);
      strobes("ur", 8, 0);
    end
    push_crc();
    strobes("ur_crc", 16, 0);
    chk16("ur_same_crc", rx_tail(rx_q), crc_b2b);
    finish_pkt("ur");
`endif

    // Reset during the CRC phase, then a clean empty packet.
    pulse_start(1'b1);
    push_crc();
    strobes("rst", 5, 0);
    #2;
    nRst = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    exp_q.delete();
    cyc(1);
    nRst = 1'b1;
    cyc(1);
    pulse_start(1'b1);
    push_crc();
    strobes("post_rst", 16, 0);
    chk16("post_rst_bits", rx_tail(rx_q), 16'h0000);
    finish_pkt("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
